// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: round-robin grant among three MSI processors, then a
// REQ/SNOOP/WB/MEM/DONE transaction sequence on the shared 11-bit bus.
module snoop_bus_arbiter #(
  parameter int SNOOP_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [10:0] p1_msg,
  input  logic [10:0] p2_msg,
  input  logic [10:0] p3_msg,
  input  logic [2:0]  flush,
  input  logic [10:0] mem_msg,
  input  logic        mem_valid,
  output logic [2:0]  gnt,
  output logic [10:0] bus_msg,
  output logic        bus_valid,
  output logic        mem_req,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_SNOOP = 3'd2,
    S_WB    = 3'd3,
    S_MEM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_GNT  = 2'd1,
    SEL_HOLD = 2'd2,
    SEL_WB   = 2'd3
  } sel_t;

  localparam logic [2:0] SNOOP_LAST  = 3'(SNOOP_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state_r;
  sel_t        sel_r;
  logic [2:0]  gnt_r;
  logic [1:0]  last_r;
  logic [10:0] msg_r;
  logic [1:0]  op_r;
  logic [2:0]  flush_acc_r;
  logic [2:0]  wb_sel_r;
  logic [2:0]  snoop_cnt_r;
  logic [7:0]  mem_cnt_r;
  logic        bus_valid_r;
  logic        mem_req_r;
  logic        done_r;
  logic        timeout_err_r;

  logic [2:0]  pick_s;
  logic [1:0]  gid_s;
  logic [10:0] gmsg_s;
  logic [2:0]  acc_s;
  logic [10:0] base_msg_s;

  // First requester strictly after the last granted id, cycling 1->2->3->1.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] p;
    p = 3'b000;
    case (last)
      2'd1:    p = r[1] ? 3'b010 : (r[2] ? 3'b100 : (r[0] ? 3'b001 : 3'b000));
      2'd2:    p = r[2] ? 3'b100 : (r[0] ? 3'b001 : (r[1] ? 3'b010 : 3'b000));
      default: p = r[0] ? 3'b001 : (r[1] ? 3'b010 : (r[2] ? 3'b100 : 3'b000));
    endcase
    return p;
  endfunction

  function automatic logic [2:0] lowest_one(input logic [2:0] v);
    logic [2:0] p;
    p = v[0] ? 3'b001 : (v[1] ? 3'b010 : (v[2] ? 3'b100 : 3'b000));
    return p;
  endfunction

  function automatic logic [1:0] onehot_id(input logic [2:0] oh);
    logic [1:0] id;
    case (oh)
      3'b001:  id = 2'd1;
      3'b010:  id = 2'd2;
      3'b100:  id = 2'd3;
      default: id = 2'd0;
    endcase
    return id;
  endfunction

  function automatic logic [10:0] msg_of(input logic [2:0] oh, input logic [10:0] m1,
                                         input logic [10:0] m2, input logic [10:0] m3);
    logic [10:0] m;
    case (oh)
      3'b001:  m = m1;
      3'b010:  m = m2;
      3'b100:  m = m3;
      default: m = 11'd0;
    endcase
    return m;
  endfunction

  assign pick_s = rr_pick(req, last_r);
  assign gid_s  = onehot_id(gnt_r);
  assign gmsg_s = msg_of(gnt_r, p1_msg, p2_msg, p3_msg);
  // The granted processor's own flush bit never counts as a supplier.
  assign acc_s  = flush_acc_r | (flush & ~gnt_r);

  // Bus source mux driven by the registered select.
  always_comb begin
    base_msg_s = 11'd0;
    case (sel_r)
      SEL_GNT:  base_msg_s = gmsg_s;
      SEL_HOLD: base_msg_s = msg_r;
      SEL_WB:   base_msg_s = msg_of(wb_sel_r, p1_msg, p2_msg, p3_msg);
      default:  base_msg_s = 11'd0;
    endcase
  end

  assign bus_msg = (state_r == S_MEM && mem_valid) ? mem_msg : base_msg_s;

  // Transaction FSM with all control outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      sel_r         <= SEL_NONE;
      gnt_r         <= 3'b000;
      last_r        <= 2'd3;
      msg_r         <= 11'd0;
      op_r          <= 2'b00;
      flush_acc_r   <= 3'b000;
      wb_sel_r      <= 3'b000;
      snoop_cnt_r   <= 3'd0;
      mem_cnt_r     <= 8'd0;
      bus_valid_r   <= 1'b0;
      mem_req_r     <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (req != 3'b000) begin
            gnt_r       <= pick_s;
            bus_valid_r <= 1'b1;
            sel_r       <= SEL_GNT;
            state_r     <= S_REQ;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_REQ: begin
          if (gmsg_s[10:9] == 2'b00) begin
            gnt_r       <= 3'b000;
            bus_valid_r <= 1'b0;
            sel_r       <= SEL_NONE;
            last_r      <= gid_s;
            state_r     <= S_IDLE;
          end else begin
            op_r        <= gmsg_s[10:9];
            msg_r       <= gmsg_s;
            sel_r       <= SEL_HOLD;
            snoop_cnt_r <= 3'd0;
            flush_acc_r <= 3'b000;
            state_r     <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          flush_acc_r <= acc_s;
          if (snoop_cnt_r == SNOOP_LAST) begin
            bus_valid_r <= 1'b0;
            if (op_r == 2'b11) begin
              done_r  <= 1'b1;
              gnt_r   <= 3'b000;
              sel_r   <= SEL_NONE;
              last_r  <= gid_s;
              state_r <= S_DONE;
            end else if (acc_s != 3'b000) begin
              wb_sel_r  <= lowest_one(acc_s);
              sel_r     <= SEL_WB;
              mem_req_r <= 1'b1;
              state_r   <= S_WB;
            end else begin
              mem_cnt_r <= 8'd0;
              mem_req_r <= 1'b1;
              state_r   <= S_MEM;
            end
          end else begin
            snoop_cnt_r <= snoop_cnt_r + 3'd1;
          end
        end
        S_WB: begin
          sel_r     <= SEL_HOLD;
          mem_cnt_r <= 8'd0;
          state_r   <= S_MEM;
        end
        S_MEM: begin
          // Timeout pulse occupies the last MEM cycle, so DONE follows it.
          if (mem_valid || mem_cnt_r == TIMEOUT_CNT) begin
            done_r        <= 1'b1;
            gnt_r         <= 3'b000;
            mem_req_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            sel_r         <= SEL_NONE;
            last_r        <= gid_s;
            state_r       <= S_DONE;
          end else begin
            mem_cnt_r     <= mem_cnt_r + 8'd1;
            timeout_err_r <= ((mem_cnt_r + 8'd1) == TIMEOUT_CNT);
          end
        end
        default: begin
          state_r     <= S_IDLE;
          sel_r       <= SEL_NONE;
          gnt_r       <= 3'b000;
          bus_valid_r <= 1'b0;
          mem_req_r   <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_r;
  assign bus_valid   = bus_valid_r;
  assign mem_req     = mem_req_r;
  assign done        = done_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Randomized bench for snoop_bus_arbiter: a transaction-level model expands
// each request into the expected per-cycle bus timeline.
module tb_snoop_bus_arbiter;

  localparam int SNOOP = 2;
  localparam int TMO   = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [10:0] p1_msg, p2_msg, p3_msg;
  logic [2:0]  flush;
  logic [10:0] mem_msg;
  logic        mem_valid;
  logic [2:0]  gnt;
  logic [10:0] bus_msg;
  logic        bus_valid, mem_req, done, timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int ptr         = 3;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  flush;
    logic        mv;
    logic [2:0]  gnt;
    logic        bv;
    logic        mr;
    logic        dn;
    logic        te;
    logic [10:0] msg;
  } cyc_t;

  snoop_bus_arbiter #(.SNOOP_CYCLES(SNOOP), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .p1_msg(p1_msg), .p2_msg(p2_msg), .p3_msg(p3_msg),
    .flush(flush), .mem_msg(mem_msg), .mem_valid(mem_valid),
    .gnt(gnt), .bus_msg(bus_msg), .bus_valid(bus_valid),
    .mem_req(mem_req), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int pick_id(input logic [2:0] r, input int last);
    int id;
    for (int k = 1; k <= 3; k++) begin
      id = ((last - 1 + k) % 3) + 1;
      if (r[id-1]) return id;
    end
    return 0;
  endfunction

  function automatic logic [10:0] mk(input int op, input int src);
    logic [10:0] m;
    m = {2'(op), 2'(src), 7'($urandom_range(0, 127))};
    return m;
  endfunction

  function automatic cyc_t noise(input bit noisy, input logic [2:0] r);
    cyc_t c;
    c = '{default: '0};
    c.req   = noisy ? 3'($urandom_range(0, 7)) : r;
    c.flush = (noisy && $urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
    c.mv    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    return c;
  endfunction

  // Expand one transaction into its expected cycle timeline, then play it.
  task automatic run_txn(input string name, input logic [2:0] r,
                         input logic [10:0] m1, input logic [10:0] m2, input logic [10:0] m3,
                         input logic [10:0] mm, input int delay, input int fpat,
                         input bit chained_in, input bit chain_out,
                         output bit pending, output logic [2:0] seen);
    cyc_t        q[$];
    cyc_t        c;
    logic [10:0] msgs [1:3];
    logic [2:0]  gm, acc;
    logic [1:0]  op;
    logic [17:0] got, want;
    int          gid, lo, last_k;
    bit          noisy;
    noisy   = (fpat < 0);
    msgs[1] = m1; msgs[2] = m2; msgs[3] = m3;
    gid     = pick_id(r, ptr);
    gm      = 3'(1 << (gid - 1));
    op      = msgs[gid][10:9];
    pending = 1'b0;
    c = '{default: '0}; c.req = r; c.dn = chained_in; q.push_back(c);
    c = noise(noisy, r); c.gnt = gm; c.bv = 1'b1; c.msg = msgs[gid]; q.push_back(c);
    if (op != 2'b00) begin
      acc = 3'b000;
      for (int s = 0; s < SNOOP; s++) begin
        c = noise(noisy, r);
        if (fpat >= 0) c.flush = 3'(fpat);
        acc = acc | (c.flush & ~gm);
        c.gnt = gm; c.bv = 1'b1; c.msg = msgs[gid]; q.push_back(c);
      end
      if (op != 2'b11) begin
        if (acc != 3'b000) begin
          lo = acc[0] ? 1 : (acc[1] ? 2 : 3);
          c = noise(noisy, r); c.gnt = gm; c.mr = 1'b1; c.msg = msgs[lo]; q.push_back(c);
        end
        last_k = (delay < 0) ? TMO : delay;
        for (int k = 0; k <= last_k; k++) begin
          c = noise(noisy, r);
          c.mv  = (k == delay);
          c.gnt = gm; c.mr = 1'b1;
          c.te  = (delay < 0 && k == TMO);
          c.msg = (k == delay) ? mm : msgs[gid];
          q.push_back(c);
        end
      end
      if (chain_out) pending = 1'b1;
      else begin
        c = '{default: '0}; c.dn = 1'b1; q.push_back(c);
      end
    end
    ptr  = gid;
    seen = 3'b000;
    foreach (q[i]) begin
      @(posedge clk); #1;
      if (i == 0) begin
        p1_msg = m1; p2_msg = m2; p3_msg = m3; mem_msg = mm;
      end
      req = q[i].req; flush = q[i].flush; mem_valid = q[i].mv;
      #1;
      if (i == 1) seen = gnt;
      got  = {gnt, bus_valid, mem_req, done, timeout_err, bus_msg};
      want = {q[i].gnt, q[i].bv, q[i].mr, q[i].dn, q[i].te, q[i].msg};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got gnt=%b bv=%b mr=%b done=%b to=%b msg=%h, expected gnt=%b bv=%b mr=%b done=%b to=%b msg=%h",
                 name, i, gnt, bus_valid, mem_req, done, timeout_err, bus_msg,
                 q[i].gnt, q[i].bv, q[i].mr, q[i].dn, q[i].te, q[i].msg);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 3'b000; flush = 3'b000; mem_valid = 1'b0;
    p1_msg = 11'd0; p2_msg = 11'd0; p3_msg = 11'd0; mem_msg = 11'd0;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({gnt, bus_valid, mem_req, done, timeout_err, bus_msg} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0", {gnt, bus_valid, mem_req, done, timeout_err, bus_msg});
    end
    @(negedge clk); rst_n = 1'b1; ptr = 3;
    @(posedge clk); #2;
    vectors++;
    if ({gnt, bus_valid, mem_req, done, timeout_err, bus_msg} !== 18'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h, expected 0", {gnt, bus_valid, mem_req, done, timeout_err, bus_msg});
    end
  endtask

  task automatic test_round_robin;
    bit          pend;
    logic [2:0]  s1, s2, s3, s4;
    run_txn("rr1", 3'b111, mk(1, 1), mk(1, 2), mk(2, 3), mk(0, 0), 1, 0, 1'b0, 1'b1, pend, s1);
    run_txn("rr2", 3'b111, mk(1, 1), mk(1, 2), mk(2, 3), mk(0, 0), 0, 0, pend, 1'b1, pend, s2);
    run_txn("rr3", 3'b111, mk(1, 1), mk(1, 2), mk(2, 3), mk(0, 0), 2, 0, pend, 1'b0, pend, s3);
    run_txn("rr4", 3'b101, mk(1, 1), mk(1, 2), mk(1, 3), mk(0, 0), 1, 0, 1'b0, 1'b0, pend, s4);
    vectors++;
    if ({s1, s2, s3, s4} !== {3'b001, 3'b010, 3'b100, 3'b001}) begin
      miscompares++;
      $display("FAIL rr_order: got %b %b %b %b, expected 001 010 100 001", s1, s2, s3, s4);
    end
  endtask

  task automatic test_basic_read;
    bit pend; logic [2:0] s;
    run_txn("basic_read", 3'b001, 11'b01_01_0000101, mk(1, 2), mk(1, 3), mk(0, 0), 2, 0,
            1'b0, 1'b0, pend, s);
    vectors++;
    if (s !== 3'b001) begin
      miscompares++;
      $display("FAIL basic_gnt: got %b, expected 001", s);
    end
  endtask

  task automatic test_writeback;
    bit pend; logic [2:0] s;
    run_txn("writeback", 3'b010, mk(1, 1), mk(2, 2), mk(3, 3), mk(1, 0), 1, 5, 1'b0, 1'b0, pend, s);
    run_txn("wb_self_masked", 3'b100, mk(2, 1), mk(1, 2), mk(2, 3), mk(1, 0), 0, 4, 1'b0, 1'b0, pend, s);
  endtask

  task automatic test_upgrade;
    bit pend; logic [2:0] s;
    run_txn("upgrade", 3'b100, mk(1, 1), mk(1, 2), mk(3, 3), mk(0, 0), 0, 2, 1'b0, 1'b0, pend, s);
  endtask

  task automatic test_timeout;
    bit pend; logic [2:0] s;
    run_txn("timeout", 3'b001, mk(1, 1), mk(1, 2), mk(1, 3), mk(0, 0), -1, 0, 1'b0, 1'b0, pend, s);
    run_txn("after_timeout", 3'b001, mk(1, 1), mk(1, 2), mk(1, 3), mk(2, 0), 0, 0, 1'b0, 1'b0, pend, s);
  endtask

  task automatic test_null;
    bit pend; logic [2:0] s;
    run_txn("null_req", 3'b010, mk(1, 1), mk(0, 2), mk(1, 3), mk(0, 0), 0, 0, 1'b0, 1'b0, pend, s);
    run_txn("after_null", 3'b110, mk(1, 1), mk(1, 2), mk(1, 3), mk(3, 0), 1, 0, 1'b0, 1'b0, pend, s);
  endtask

  task automatic test_random;
    bit pend; logic [2:0] s;
    int delay;
    pend = 1'b0;
    for (int t = 0; t < 40; t++) begin
      delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      run_txn("random", 3'($urandom_range(1, 7)),
              mk($urandom_range(0, 3), 1), mk($urandom_range(0, 3), 2), mk($urandom_range(0, 3), 3),
              mk($urandom_range(0, 3), 0), delay, -1, pend, (t != 39) && ($urandom_range(0, 1) == 1),
              pend, s);
    end
  endtask

  task automatic test_reset_mid;
    bit pend; logic [2:0] s;
    @(posedge clk); #1;
    req = 3'b001; p1_msg = mk(1, 1); flush = 3'b000; mem_valid = 1'b0;
    @(posedge clk); #1; req = 3'b000;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({gnt, mem_req} !== {3'b001, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_mem_reached: got gnt=%b mr=%b, expected 001 1", gnt, mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, bus_valid, mem_req, done, timeout_err, bus_msg} !== 18'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h, expected 0", {gnt, bus_valid, mem_req, done, timeout_err, bus_msg});
    end
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({gnt, bus_valid, mem_req, done, timeout_err} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %b, expected 0", {gnt, bus_valid, mem_req, done, timeout_err});
    end
    @(negedge clk); rst_n = 1'b1; ptr = 3;
    run_txn("post_reset_p2", 3'b010, mk(1, 1), mk(1, 2), mk(1, 3), mk(0, 0), 0, 0, 1'b0, 1'b0, pend, s);
    vectors++;
    if (s !== 3'b010) begin
      miscompares++;
      $display("FAIL post_reset_grant: got %b, expected 010", s);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic_read();
    test_writeback();
    test_upgrade();
    test_timeout();
    test_null();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
